// File: rtl/bin2csd_seq.sv
// bin2csd_seq: serial LSB-first Reitwiesner binary-to-CSD recoder with digit stream, parallel word and non-zero count
module bin2csd_seq #(
  parameter int W      = 16,
  parameter int SIGNED = 0,
  parameter int CNT_W  = $clog2(W + 2)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     x,
  output logic             dig_valid,
  output logic [1:0]       dig,
  output logic             dig_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*W+1:0]   y,
  output logic [CNT_W-1:0] nz_cnt
);
  localparam int N = (SIGNED != 0) ? W : W + 1;
  localparam int IW = $clog2(W + 2);
  localparam logic [IW-1:0] LAST = IW'(N - 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t r_state, w_next;
  logic [W-1:0] r_x;
  logic r_c, r_dv, r_dl;
  logic [IW-1:0] r_i, w_i1;
  logic [1:0] r_dig, w_d;
  logic [2*W+1:0] r_y, w_y;
  logic [CNT_W-1:0] r_nz;
  logic [W+1:0] w_xe;
  logic w_xi, w_xn, w_cn, w_nz, w_last;
  // operand extended by two bits so digit N-1 can look at x_{N}
  assign w_xe   = {{2{(SIGNED != 0) ? r_x[W-1] : 1'b0}}, r_x};
  assign w_i1   = r_i + 1'b1;
  assign w_xi   = w_xe[r_i];
  assign w_xn   = w_xe[w_i1];
  assign w_cn   = (w_xi & w_xn) | (w_xi & r_c) | (w_xn & r_c);
  assign w_nz   = w_xi ^ r_c;
  assign w_d    = w_nz ? (w_xn ? 2'b10 : 2'b01) : 2'b00;
  assign w_last = r_i == LAST;
  assign w_y    = r_y | ({{(2*W){1'b0}}, w_d} << {r_i, 1'b0});
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else if (ena) r_state <= w_next;
  always_comb
    w_next = (r_state == IDLE) ? (in_valid ? RUN : IDLE) :
             (r_state == RUN)  ? (w_last ? DONE : RUN) :
             (out_ready ? IDLE : DONE);
  always_comb begin
    in_ready  = r_state == IDLE;
    out_valid = r_state == DONE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_x   <= '0;
      r_c   <= 1'b0;
      r_i   <= '0;
      r_y   <= '0;
      r_nz  <= '0;
      r_dig <= 2'b00;
      r_dv  <= 1'b0;
      r_dl  <= 1'b0;
    end else if (ena) begin
      r_dv <= 1'b0;
      r_dl <= 1'b0;
      if (r_state == IDLE && in_valid) begin
        r_x  <= x;
        r_c  <= 1'b0;
        r_i  <= '0;
        r_y  <= '0;
        r_nz <= '0;
      end else if (r_state == RUN) begin
        r_dig <= w_d;
        r_dv  <= 1'b1;
        r_dl  <= w_last;
        r_y   <= w_y;
        r_nz  <= r_nz + CNT_W'(w_nz);
        r_c   <= w_cn;
        r_i   <= w_i1;
      end
    end
  assign dig_valid = r_dv;
  assign dig       = r_dig;
  assign dig_last  = r_dl;
  assign y         = r_y;
  assign nz_cnt    = r_nz;
endmodule
